// File: rtl/matmul_pkg.sv
// Shared types and default sizing for the matrix-product sequencer.
// The optional sticky overflow flag is enabled with MATMUL_OVF_FLAG_EN (see matmul_ctrl).
package matmul_pkg;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  localparam int M_DEF  = 2;
  localparam int DW_DEF = 8;
  localparam int RW_DEF = 3 * DW_DEF;

  localparam int IDXW = (M_DEF > 1) ? $clog2(M_DEF) : 1;

endpackage

// File: rtl/matmul_idx_counter.sv
// Nested k (inner), j, i (outer) index counters for walking an MxM product.
// k advances per MAC step; inc_ij ends an element by clearing k and stepping j/i.
module matmul_idx_counter #(
  parameter int M  = 2,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc_k,
  input  logic          inc_ij,
  output logic [DW-1:0] i,
  output logic [DW-1:0] j,
  output logic [DW-1:0] k,
  output logic          last_k,
  output logic          last_elem
);

  localparam logic [DW-1:0] LAST = DW'(M - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (inc_ij) begin
      k <= '0;
      if (j == LAST) begin
        j <= '0;
        i <= i + DW'(1);
      end else begin
        j <= j + DW'(1);
      end
    end else if (inc_k) begin
      k <= k + DW'(1);
    end
  end

  assign last_k    = (k == LAST);
  assign last_elem = (i == LAST) && (j == LAST);

endmodule

// File: rtl/matmul_ctrl.sv
// Sequences C = A x B: M MAC cycles then one WRITE per element, then a DONE pulse.
// Define MATMUL_OVF_FLAG_EN to add the sticky ovf output (result exceeded DW bits).
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int M  = M_DEF,
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] aRow,
  output logic [DW-1:0] aCol,
  output logic [DW-1:0] bRow,
  output logic [DW-1:0] bCol,
  input  logic [DW-1:0] aData,
  input  logic [DW-1:0] bData,
  output logic          writeEn,
  output logic [DW-1:0] rowSel,
  output logic [DW-1:0] colSel,
  output logic [RW-1:0] in
`ifdef MATMUL_OVF_FLAG_EN
  ,
  output logic          ovf
`endif
);

  state_t          state;
  logic [RW-1:0]   acc;
  logic [DW-1:0]   i, j, k;
  logic            lastK, lastElem;
  logic            clr, incK, incIj;
  logic            macPhase, wrPhase;
  logic [2*DW-1:0] prod;

  assign macPhase = (state == MAC);
  assign wrPhase  = (state == WRITE);

  // Operands widened first so the product keeps all 2*DW bits.
  assign prod = {{DW{1'b0}}, aData} * {{DW{1'b0}}, bData};

  assign clr   = ((state == IDLE) && start) || (wrPhase && lastElem);
  assign incK  = macPhase && !lastK;
  assign incIj = wrPhase && !lastElem;

  matmul_idx_counter #(
    .M  (M),
    .DW (DW)
  ) idxCounter (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .inc_k     (incK),
    .inc_ij    (incIj),
    .i         (i),
    .j         (j),
    .k         (k),
    .last_k    (lastK),
    .last_elem (lastElem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      writeEn <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= MAC;
            busy  <= 1'b1;
          end
        end
        MAC: begin
          // k==0 starts a fresh dot product, so no residue survives between elements or runs.
          acc <= ((k == '0) ? '0 : acc) + RW'(prod);
          if (lastK) begin
            state   <= WRITE;
            writeEn <= 1'b1;
          end
        end
        WRITE: begin
          writeEn <= 1'b0;
          if (lastElem) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= MAC;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Addresses are only meaningful in their own phase; zero elsewhere keeps the buses quiet.
  assign aRow   = macPhase ? i : '0;
  assign aCol   = macPhase ? k : '0;
  assign bRow   = macPhase ? k : '0;
  assign bCol   = macPhase ? j : '0;
  assign rowSel = wrPhase  ? i : '0;
  assign colSel = wrPhase  ? j : '0;
  assign in     = acc;

`ifdef MATMUL_OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if ((state == IDLE) && start) begin
      ovf <= 1'b0;
    end else if (wrPhase && (acc[RW-1:DW] != '0)) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule
